// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-to-host frame receiver.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } ps2_state_t;

    // True when data plus parity bit together hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus FILTER_LEN-deep agreement filter for one PS/2 line.
// The filtered level only moves once every sample in the window agrees.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    logic [1:0]            sync_reg;
    logic [FILTER_LEN-1:0] window_reg;
    logic                  level_reg;
    logic                  prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg   <= '1;
            window_reg <= '1;
            level_reg  <= 1'b1;
            prev_reg   <= 1'b1;
        end else begin
            sync_reg   <= {sync_reg[0], line};
            window_reg <= {window_reg[FILTER_LEN-2:0], sync_reg[1]};
            if (&window_reg)
                level_reg <= 1'b1;
            else if (~|window_reg)
                level_reg <= 1'b0;
            prev_reg   <= level_reg;
        end
    end

    assign level = level_reg;
    assign fall  = prev_reg & ~level_reg;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: filtered lines, 11-bit frame, start/stop/timeout checks.
// Define PS2_PARITY_CHECK_EN to also drop frames with bad odd parity.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       frame_err,
    output logic       busy
);

    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic clk_level_unused;
    logic data_fall_unused;
    logic data_level;
    logic clk_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .line  (ps2c),
        .level (clk_level_unused),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .line  (ps2d),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    ps2_state_t                state_reg, state_next;
    logic [PS2_FRAME_BITS-1:0] shift_reg, shift_next;
    logic [3:0]                cnt_reg, cnt_next;
    logic [TMO_W-1:0]          tmo_reg, tmo_next;
    logic [7:0]                dout_reg, dout_next;
    logic                      done_reg, done_next;
    logic                      err_reg, err_next;
    logic                      frame_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            tmo_reg   <= '0;
            dout_reg  <= 8'h00;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            tmo_reg   <= tmo_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // The verdict is taken on the stop-bit fall and registered, so both pulses
    // line up with the single CHECK cycle.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        tmo_next   = tmo_reg;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        frame_ok   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clk_fall && rx_en) begin
                    state_next = DATA;
                    shift_next = {data_level, shift_reg[PS2_FRAME_BITS-1:1]};
                    cnt_next   = 4'd10;
                    tmo_next   = '0;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    shift_next = {data_level, shift_reg[PS2_FRAME_BITS-1:1]};
                    cnt_next   = cnt_reg - 4'd1;
                    tmo_next   = '0;
                    if (cnt_reg == 4'd1) begin
                        state_next = CHECK;
                        frame_ok   = ~shift_next[0] & shift_next[10];
`ifdef PS2_PARITY_CHECK_EN
                        frame_ok   = frame_ok & odd_parity_ok(shift_next[8:1], shift_next[9]);
`endif
                        if (frame_ok) begin
                            dout_next = shift_next[8:1];
                            done_next = 1'b1;
                        end else begin
                            err_next  = 1'b1;
                        end
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else if (tmo_reg != '1) begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            CHECK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_done_tick = done_reg;
    assign frame_err    = err_reg;
    assign dout         = dout_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx; honours PS2_PARITY_CHECK_EN like the design.
module tb_ps2_frame_rx;

    localparam int TIMEOUT = 2000;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rx_en = 1'b1;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    ps2_frame_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rx_en        (rx_en),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] data,
                                               input logic flip_par,
                                               input logic stop);
        return {stop, (~^data) ^ flip_par, data, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2d = frame[i];
            repeat (HALF) @(negedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic settle(input string tag);
        repeat (40) @(negedge clk);
        check_val({tag, "_pending"}, exp_q.size(), 0);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    // Scoreboard: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rx_done_tick || frame_err) begin
            check_val("exclusive", rx_done_tick & frame_err, 0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", {rx_done_tick, frame_err}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("event: done=%0b err=%0b dout=%02h (exp err=%0b data=%02h)",
                         rx_done_tick, frame_err, dout, e.is_err, e.data);
                check_val("pulse_kind", frame_err, e.is_err);
                if (!e.is_err) check_val("dout", dout, e.data);
            end
        end
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_dout", dout, 8'h00);
        check_val("reset_done", rx_done_tick, 0);
        check_val("reset_err", frame_err, 0);

        // 1: single good frame
        exp_q.push_back('{1'b0, 8'h29});
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 11);
        settle("t1");
        check_val("t1_dout_hold", dout, 8'h29);

        // 2: back-to-back press/release
        exp_q.push_back('{1'b0, 8'hF0});
        exp_q.push_back('{1'b0, 8'h29});
        send_bits(make_frame(8'hF0, 1'b0, 1'b1), 11);
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 11);
        settle("t2");

        // 3: parity flipped (0x4B so a dropped byte leaves dout distinguishable)
`ifdef PS2_PARITY_CHECK_EN
        exp_q.push_back('{1'b1, 8'h00});
        send_bits(make_frame(8'h4B, 1'b1, 1'b1), 11);
        settle("t3");
        check_val("t3_dout", dout, 8'h29);
`else
        exp_q.push_back('{1'b0, 8'h4B});
        send_bits(make_frame(8'h4B, 1'b1, 1'b1), 11);
        settle("t3");
        check_val("t3_dout", dout, 8'h4B);
`endif

        // 4: bad stop bit
        exp_q.push_back('{1'b1, 8'h00});
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11);
        settle("t4");
`ifdef PS2_PARITY_CHECK_EN
        check_val("t4_dout", dout, 8'h29);
`else
        check_val("t4_dout", dout, 8'h4B);
`endif

        // 4b: bad start bit
        exp_q.push_back('{1'b1, 8'h00});
        send_bits(make_frame(8'h33, 1'b0, 1'b1) | 11'h001, 11);
        settle("t4b");

        // 5: truncated frame then timeout, then recovery
        exp_q.push_back('{1'b1, 8'h00});
        send_bits(make_frame(8'h77, 1'b0, 1'b1), 5);
        repeat (20) @(negedge clk);
        check_val("t5_busy_mid", busy, 1);
        repeat (TIMEOUT + 10) @(negedge clk);
        check_val("t5_busy_after", busy, 0);
        check_val("t5_pending", exp_q.size(), 0);
        exp_q.push_back('{1'b0, 8'h5A});
        send_bits(make_frame(8'h5A, 1'b0, 1'b1), 11);
        settle("t5b");

        // 6a: short glitches on ps2c while idle
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            ps2c = 1'b0;
            repeat (3) @(negedge clk);
            ps2c = 1'b1;
            repeat (15) @(negedge clk);
            check_val("t6_glitch_busy", busy, 0);
        end

        // 6b: rx_en low for a whole frame
        rx_en = 1'b0;
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 11);
        settle("t6_rx_en");
        rx_en = 1'b1;
        check_val("t6_rx_en_dout", dout, 8'h5A);

        // 6c: reset mid-frame
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 5);
        repeat (20) @(negedge clk);
        check_val("t6_busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check_val("t6_busy_after_reset", busy, 0);
        check_val("t6_dout_after_reset", dout, 8'h00);
        reset = 1'b0;
        settle("t6_reset");

        // final good frame after reset
        exp_q.push_back('{1'b0, 8'h1C});
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11);
        settle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
